// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: widths, the NOP encoding and the
// fetch-buffer entry layout.
package cpu_pkg;

  localparam int              XLEN             = 16;
  localparam logic [XLEN-1:0] NOP_INSTR        = 16'hE000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; the head entry is visible
// combinationally so IF/ID sees it in the same cycle it becomes valid.
module if_fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word requests under a credit limit, buffers
// in-order responses with their PCs, and discards stale responses after redirects.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [CW-1:0]   drop_cnt_reg;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   out_cnt;
  fetch_entry_t    fifo_head, pcq_head, fifo_wdata, pcq_wdata;
  logic            fifo_full, fifo_empty, pcq_full, pcq_empty;
  logic            pop, accept, rsp_push;
  logic [SW-1:0]   credit_used, drop_next;
  logic            unused_bits;

  // Every slot that is dropping, in flight or buffered consumes one credit.
  assign pop            = !fifo_empty && !stall && !redirect_valid;
  assign credit_used    = SW'(drop_cnt_reg) + SW'(out_cnt) + SW'(fifo_count) - SW'(pop);
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_push       = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);
  assign drop_next      = SW'(drop_cnt_reg) + SW'(out_cnt) + SW'(accept) - SW'(imem_rsp_valid);

  assign pcq_wdata  = '{pc: fetch_pc_reg, instr: '0};
  assign fifo_wdata = '{pc: pcq_head.pc, instr: imem_rsp_data};

  // The PC queue occupancy is exactly the number of live outstanding requests.
  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rsp_push),
    .flush (redirect_valid),
    .wdata (pcq_wdata),
    .rdata (pcq_head),
    .count (out_cnt),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      drop_cnt_reg <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_pc;
      drop_cnt_reg <= CW'(drop_next);
    end else begin
      if (accept) fetch_pc_reg <= fetch_pc_reg + 1'b1;
      if (imem_rsp_valid && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - 1'b1;
    end
  end

  assign if_valid = !fifo_empty;
  assign if_pc    = fifo_empty ? '0 : fifo_head.pc;
  assign if_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;

  assign unused_bits = ^{pcq_head.instr, pcq_full, pcq_empty, fifo_full};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle table for start-up and stall, scoreboard of the
// presented PC stream, and hand-written redirect / backpressure / wrap / reset cases.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = 16'h0000;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_instr;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [15:0] addr;
    logic        v;
    logic [15:0] pc;
    logic [15:0] instr;
  } vec_t;
  vec_t tbl[15];

  logic [15:0] exp_q[$];
  logic [15:0] mem_q[$];
  logic        acc_s = 1'b0;
  logic [15:0] acc_addr_s = 16'h0000;
  logic        rsp_block = 1'b0;
  logic [15:0] hold_addr;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  // Memory: mem[a] = a + 0x1000, in order, one cycle after acceptance unless blocked.
  always @(negedge clk) begin
    acc_s      <= imem_req_valid && imem_req_ready;
    acc_addr_s <= imem_req_addr;
  end

  always @(posedge clk) begin
    if (rst) begin
      mem_q.delete();
      imem_rsp_valid <= 1'b0;
    end else begin
      if (acc_s) mem_q.push_back(acc_addr_s);
      if (!rsp_block && mem_q.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_q.pop_front() + 16'h1000;
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic sb_reset(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 16'(i));
  endtask

  // Negedge sample point: scoreboard every consumed instruction.
  task automatic to_neg();
    logic [15:0] e;
    @(negedge clk);
    if (!rst && if_valid && !stall && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got pc %h, expected no instruction", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_instr", if_instr, e + 16'h1000);
      end
    end
    if (!rst && dut.rsp_push)
      chk("push_full_no_pop", 16'(dut.fifo_full && !dut.pop), 16'd0);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid && n < 20) begin
      to_pos();
      to_neg();
      n++;
    end
    chk(name, 16'(if_valid), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    // Cycle k after reset: request addr k, presented pc k-2; stall on k=7..9 holds pc 5.
    for (int k = 0; k < 15; k++) begin
      tbl[k].stall = (k >= 7 && k <= 9);
      tbl[k].rv    = !(k >= 7 && k <= 9);
      tbl[k].addr  = (k < 7) ? 16'(k) : ((k <= 10) ? 16'd7 : 16'(k - 3));
      tbl[k].v     = (k >= 2);
      tbl[k].pc    = (k < 2) ? 16'd0 : ((k <= 7) ? 16'(k - 2) : ((k <= 10) ? 16'd5 : 16'(k - 5)));
      tbl[k].instr = tbl[k].v ? tbl[k].pc + 16'h1000 : NOP_INSTR;
    end

    repeat (3) @(posedge clk);
    #1;
    to_neg();
    chk("rst_req_valid", 16'(imem_req_valid), 16'd0);
    chk("rst_if_valid", 16'(if_valid), 16'd0);
    chk("rst_if_pc", if_pc, 16'h0000);
    chk("rst_if_instr", if_instr, NOP_INSTR);
    to_pos();
    rst = 1'b0;
    sb_reset(16'h0000);

    for (int i = 0; i < 15; i++) begin
      stall = tbl[i].stall;
      to_neg();
      chk($sformatf("tbl%0d_req_valid", i), 16'(imem_req_valid), 16'(tbl[i].rv));
      chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_if_valid", i), 16'(if_valid), 16'(tbl[i].v));
      chk($sformatf("tbl%0d_if_pc", i), if_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_if_instr", i), if_instr, tbl[i].instr);
      to_pos();
    end
    stall = 1'b0;

    // Redirect with two requests held in flight by the memory.
    rsp_block = 1'b1;
    repeat (5) begin to_neg(); to_pos(); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    rsp_block      = 1'b0;
    sb_reset(16'h0100);
    to_neg();
    chk("redir_req_valid", 16'(imem_req_valid), 16'd0);
    to_pos();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk($sformatf("redir_drop%0d_if_valid", i), 16'(if_valid), 16'd0);
      if (i == 0) chk("redir_req_addr", imem_req_addr, 16'h0100);
      to_pos();
    end
    to_neg();
    wait_valid("redir_first_valid");
    chk("redir_first_pc", if_pc, 16'h0100);
    to_pos();
    repeat (3) begin to_neg(); to_pos(); end

    // Request backpressure: address holds, FIFO drains to NOP.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      if (i == 0) hold_addr = imem_req_addr;
      else chk($sformatf("nrdy%0d_addr_stable", i), imem_req_addr, hold_addr);
      chk($sformatf("nrdy%0d_req_valid", i), 16'(imem_req_valid), 16'd1);
      to_pos();
    end
    to_neg();
    chk("nrdy_if_valid", 16'(if_valid), 16'd0);
    chk("nrdy_if_instr", if_instr, NOP_INSTR);
    chk("nrdy_if_pc", if_pc, 16'h0000);
    to_pos();
    imem_req_ready = 1'b1;
    to_neg();
    wait_valid("nrdy_recover");
    to_pos();

    // Fill the FIFO under stall, then redirect and stall together.
    stall = 1'b1;
    repeat (3) begin to_neg(); to_pos(); end
    to_neg();
    chk("full_req_valid", 16'(imem_req_valid), 16'd0);
    chk("full_if_valid", 16'(if_valid), 16'd1);
    to_pos();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    sb_reset(16'h0200);
    to_neg();
    chk("rs_req_valid", 16'(imem_req_valid), 16'd0);
    to_pos();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    to_neg();
    chk("rs_flushed", 16'(if_valid), 16'd0);
    chk("rs_req_valid_next", 16'(imem_req_valid), 16'd1);
    chk("rs_req_addr", imem_req_addr, 16'h0200);
    to_pos();
    to_neg();
    wait_valid("rs_first_valid");
    chk("rs_first_pc", if_pc, 16'h0200);
    to_pos();

    // PC wrap-around, then reset mid-stream.
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    sb_reset(16'hFFFE);
    to_neg();
    to_pos();
    redirect_valid = 1'b0;
    to_neg();
    wait_valid("wrap_first_valid");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap%0d_pc", i), if_pc, 16'hFFFE + 16'(i));
      to_pos();
      to_neg();
    end
    to_pos();
    rst = 1'b1;
    to_neg();
    chk("mrst_req_valid", 16'(imem_req_valid), 16'd0);
    to_pos();
    rst = 1'b0;
    sb_reset(16'h0000);
    to_neg();
    chk("mrst_if_valid", 16'(if_valid), 16'd0);
    chk("mrst_if_instr", if_instr, NOP_INSTR);
    chk("mrst_req_valid_after", 16'(imem_req_valid), 16'd1);
    chk("mrst_req_addr", imem_req_addr, 16'h0000);
    to_pos();
    repeat (6) begin to_neg(); to_pos(); end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 16-bit pipeline, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order responses. Returned words are buffered in a small FIFO and presented as if_pc/if_instr to IF/ID. It handles pipeline stalls and branch/jump redirects, including discarding stale in-flight responses.

Parameters:
RESET_PC, 16'h0000, fetch PC value after reset
FIFO_DEPTH, 2, instruction buffer entries; also the cap on (outstanding + buffered)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit; IF/ID holds; no FIFO pop
redirect_valid  in  1  taken branch/jump from EX; single-cycle pulse
redirect_pc  in  16  new fetch target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  16  word address of request
imem_rsp_valid  in  1  response word valid; in order, at least 1 cycle after acceptance
imem_rsp_data  in  16  instruction word
if_valid  out  1  FIFO head is a real instruction
if_pc  out  16  PC of FIFO head; 16'h0000 when empty
if_instr  out  16  FIFO head word; NOP 16'hE000 when empty

Behaviour:
- Reset (synchronous, rst high at clk edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0. Outputs: imem_req_valid=0 while rst high; if_valid=0, if_pc=0, if_instr=16'hE000.
- PC is word-addressed. Each accepted request (imem_req_valid && imem_req_ready) advances fetch_pc by 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- imem_req_addr=fetch_pc. Once asserted, imem_req_valid and imem_req_addr hold stable until accepted, unless a redirect occurs.
- pop = if_valid && !stall && !redirect_valid.
- imem_req_valid = !rst && (outstanding + count - pop < FIFO_DEPTH). This gives one instruction per cycle with a 1-cycle memory.
- Each buffered entry holds {pc, instr}. The entry PC is taken from a small in-order PC queue recorded at request acceptance.
- Response path: if drop>0, the response is discarded and drop decrements. Otherwise the response is pushed to the FIFO and outstanding decrements.
- Latency: request accepted at edge N, response at N+1, visible on if_instr after edge N+2. The FIFO head drives the outputs with no response bypass.
- Stall: FIFO head and outputs are held. Requests continue until the credit limit is reached. Nothing is lost or duplicated.
- Redirect (priority over stall):
  - fetch_pc becomes redirect_pc.
  - The FIFO and PC queue are flushed.
  - drop becomes the outstanding count plus any request accepted this same cycle, minus any response arriving this cycle. A response arriving this cycle is discarded.
  - outstanding becomes 0.
  - imem_req_valid is deasserted in the redirect cycle and the new PC is issued on the next cycle.
- New requests are allowed while drop>0, but only if drop + outstanding + count < FIFO_DEPTH.
- Simultaneous push and pop on a full FIFO is legal. A push on a full FIFO without a pop cannot occur by construction; the bench asserts this.
- The imem interface is reset by the same rst. No responses from before reset arrive after it.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN=16
  - NOP_INSTR=16'hE000
  - RESET_PC default
  - the fetch entry struct {pc[15:0], instr[15:0]}
- One sub-module, if_fetch_fifo: a parameterised synchronous FIFO of fetch entries with push, pop, flush, count, full and empty.
- The PC queue reuses if_fetch_fifo, with instr unused.

Test Plan:
1. Release rst, 1-cycle memory returning mem[a]=a+16'h1000, no stall: first request addr 0x0000 in the cycle after reset. if_pc/if_instr read 0x0000/0x1000 two cycles later, then 0x0001/0x1001, and so on, one per cycle with no bubbles.
2. Assert stall for 3 cycles mid-stream while head is pc 0x0005: outputs hold 0x0005. Requests stop once outstanding+count=2. After release the sequence continues 0x0006, 0x0007 with no gaps or duplicates.
3. Redirect to 0x0100 with 2 requests in flight: both stale responses are discarded, if_valid stays 0, the next request address is 0x0100, and the first presented if_pc is 0x0100.
4. imem_req_ready held low 4 cycles: imem_req_addr stays stable. The FIFO drains to if_valid=0 and if_instr=16'hE000, then recovers when ready returns.
5. Redirect and stall asserted in the same cycle, with the FIFO full: redirect wins, the FIFO is flushed, and fetch restarts at redirect_pc.
6. Start at 16'hFFFE: PCs go 0xFFFE, 0xFFFF, 0x0000, 0x0001. Then rst mid-stream: the next cycle shows if_valid=0, and the first request after reset is RESET_PC.
